// File: rtl/embox_pkg.sv
// Shared mailbox constants: register word indices and the drain FSM state encoding.
package embox_pkg;

    localparam int unsigned EMBOXLO = 6;
    localparam int unsigned EMBOXHI = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_CAPT,
        ST_HOLD
    } drain_state_e;

    // Byte address of a mailbox register: word index masked to the register-file width.
    function automatic logic [19:0] embox_addr(input logic [19:0] base,
                                               input int unsigned idx,
                                               input int unsigned rfaw);
        logic [19:0] mask;
        mask = 20'((64'd1 << rfaw) - 64'd1);
        return base | ((20'(idx) & mask) << 2);
    endfunction

endpackage

// File: rtl/embox_drain.sv
// Autonomous mailbox drain: reads low then high word of each message and
// presents the 64-bit result on a valid/ready stream.
module embox_drain
    import embox_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned RFAW      = 5,
    parameter logic [19:0] BASE_ADDR = 20'h0,
    parameter int unsigned LO_IDX    = EMBOXLO,
    parameter int unsigned HI_IDX    = EMBOXHI
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            enable,
    input  logic            embox_not_empty,
    output logic            mi_en,
    output logic            mi_we,
    output logic [19:0]     mi_addr,
    input  logic [DW-1:0]   mi_dout,
    output logic            msg_valid,
    input  logic            msg_ready,
    output logic [2*DW-1:0] msg_data,
    output logic [15:0]     drain_count
);

    localparam logic [19:0] LO_ADDR = embox_addr(BASE_ADDR, LO_IDX, RFAW);
    localparam logic [19:0] HI_ADDR = embox_addr(BASE_ADDR, HI_IDX, RFAW);

    drain_state_e    state_q, state_d;
    logic            mi_en_q, mi_en_d;
    logic [19:0]     mi_addr_q, mi_addr_d;
    logic            msg_valid_q, msg_valid_d;
    logic [2*DW-1:0] msg_data_q, msg_data_d;
    logic [15:0]     drain_count_q, drain_count_d;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The not-empty flag is only looked at in IDLE, so a stale flag during the pop is harmless.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (enable && embox_not_empty) state_d = ST_RD_LO;
            ST_RD_LO: state_d = ST_RD_HI;
            ST_RD_HI: state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_HOLD;
            ST_HOLD:  if (msg_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus strobes are registered, so they are decoded from the state being entered.
    always_comb begin
        mi_en_d       = (state_d == ST_RD_LO) || (state_d == ST_RD_HI);
        mi_addr_d     = mi_addr_q;
        msg_valid_d   = (state_d == ST_HOLD);
        msg_data_d    = msg_data_q;
        drain_count_d = drain_count_q;

        if (state_d == ST_RD_LO) begin
            mi_addr_d = LO_ADDR;
        end else if (state_d == ST_RD_HI) begin
            mi_addr_d = HI_ADDR;
        end

        if (state_q == ST_RD_HI) begin
            msg_data_d[DW-1:0] = mi_dout;
        end
        if (state_q == ST_CAPT) begin
            msg_data_d[2*DW-1:DW] = mi_dout;
        end

        if (msg_valid_q && msg_ready) begin
            drain_count_d = drain_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mi_en_q       <= 1'b0;
            mi_addr_q     <= '0;
            msg_valid_q   <= 1'b0;
            msg_data_q    <= '0;
            drain_count_q <= '0;
        end else begin
            mi_en_q       <= mi_en_d;
            mi_addr_q     <= mi_addr_d;
            msg_valid_q   <= msg_valid_d;
            msg_data_q    <= msg_data_d;
            drain_count_q <= drain_count_d;
        end
    end

    assign mi_en       = mi_en_q;
    assign mi_we       = 1'b0;
    assign mi_addr     = mi_addr_q;
    assign msg_valid   = msg_valid_q;
    assign msg_data    = msg_data_q;
    assign drain_count = drain_count_q;

endmodule

// File: tb/tb_embox_drain.sv
// Randomized bench for embox_drain against a mailbox model and an in-order message scoreboard.
module tb_embox_drain;
    import embox_pkg::*;

    localparam int unsigned DW   = 32;
    localparam logic [19:0] LO_A = 20'(EMBOXLO * 4);
    localparam logic [19:0] HI_A = 20'(EMBOXHI * 4);

    logic        clk;
    logic        nreset;
    logic        enable;
    logic        embox_not_empty;
    logic        mi_en;
    logic        mi_we;
    logic [19:0] mi_addr;
    logic [31:0] mi_dout = '0;
    logic        msg_valid;
    logic        msg_ready;
    logic [63:0] msg_data;
    logic [15:0] drain_count;

    int total = 0;
    int bad   = 0;

    logic [63:0] mem [256];
    logic [7:0]  push_cnt = '0;
    logic [7:0]  pop_cnt  = '0;
    logic [63:0] exp_q [$];
    logic [15:0] exp_cnt;

    embox_drain #(
        .DW       (DW),
        .RFAW     (5),
        .BASE_ADDR(20'h0),
        .LO_IDX   (EMBOXLO),
        .HI_IDX   (EMBOXHI)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .enable         (enable),
        .embox_not_empty(embox_not_empty),
        .mi_en          (mi_en),
        .mi_we          (mi_we),
        .mi_addr        (mi_addr),
        .mi_dout        (mi_dout),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .msg_data       (msg_data),
        .drain_count    (drain_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mailbox: read data one cycle after the strobe; reading the high word pops.
    assign embox_not_empty = (push_cnt != pop_cnt);
    always @(posedge clk) begin
        if (mi_en) begin
            if (mi_addr == LO_A) begin
                mi_dout <= mem[pop_cnt][31:0];
            end else if (mi_addr == HI_A) begin
                mi_dout <= mem[pop_cnt][63:32];
                pop_cnt <= pop_cnt + 8'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] m);
        mem[push_cnt] = m;
        push_cnt      = push_cnt + 8'd1;
        exp_q.push_back(m);
    endtask

    task automatic wait_lo(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mi_en && mi_addr == LO_A) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("lo_timeout", 64'd0, 64'd1);
    endtask

    // One full message: LO read, HI read, capture, HOLD for 'stall' cycles, then accept.
    task automatic deliver(input int unsigned stall, input bit drop_en);
        bit          ok;
        logic [63:0] m;
        wait_lo(ok);
        if (!ok) return;
        if (drop_en) enable = 1'b0;
        m = exp_q.pop_front();
        tick();
        check("hi_follows_lo", 64'({mi_en, mi_addr}), 64'({1'b1, HI_A}));
        tick();
        check("capt_bus_idle", 64'({mi_en, msg_valid}), 64'd0);
        tick();
        check("valid_at_3", 64'(msg_valid), 64'd1);
        check("msg_data", msg_data, m);
        if (stall > 0) begin
            msg_ready = 1'b0;
            for (int unsigned i = 0; i < stall; i++) begin
                tick();
                check("stall_valid_noread", 64'({mi_en, msg_valid}), 64'd1);
                check("stall_data", msg_data, m);
            end
        end
        msg_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check("drain_count", 64'(drain_count), 64'(exp_cnt));
        check("valid_drop", 64'(msg_valid), 64'd0);
    endtask

    initial begin
        bit          saw_en;
        bit          ok;
        logic [7:0]  pop_before;
        int unsigned n;

        nreset    = 1'b0;
        enable    = 1'b0;
        msg_ready = 1'b0;
        exp_cnt   = '0;
        repeat (3) tick();
        check("rst_mi_en", 64'(mi_en), 64'd0);
        check("rst_mi_we", 64'(mi_we), 64'd0);
        check("rst_mi_addr", 64'(mi_addr), 64'd0);
        check("rst_valid", 64'(msg_valid), 64'd0);
        check("rst_data", msg_data, 64'd0);
        check("rst_count", 64'(drain_count), 64'd0);

        nreset = 1'b1;
        enable = 1'b1;
        saw_en = 1'b0;
        repeat (10) begin
            tick();
            if (mi_en || msg_valid) saw_en = 1'b1;
        end
        check("idle_empty_quiet", 64'(saw_en), 64'd0);

        // Single known message
        msg_ready = 1'b1;
        push({32'hCAFEF00D, 32'h12345678});
        deliver(0, 1'b0);

        // Back-pressure with two queued
        enable = 1'b0;
        push({$urandom(), $urandom()});
        push({$urandom(), $urandom()});
        enable = 1'b1;
        deliver(10, 1'b0);
        deliver(0, 1'b0);

        // Enable drop mid-message with more queued
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push({$urandom(), $urandom()});
        enable = 1'b1;
        deliver(0, 1'b1);
        saw_en = 1'b0;
        repeat (15) begin
            tick();
            if (mi_en) saw_en = 1'b1;
        end
        check("disabled_no_read", 64'(saw_en), 64'd0);
        check("still_queued", 64'(8'(push_cnt - pop_cnt)), 64'd3);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) deliver($urandom_range(3, 0), 1'b0);

        // Randomized bursts
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(4, 1);
            for (int unsigned i = 0; i < n; i++) push({$urandom(), $urandom()});
            for (int unsigned i = 0; i < n; i++) deliver($urandom_range(3, 0), 1'b0);
        end

        // Reset during CAPT: popped message is lost, next one drains
        enable = 1'b0;
        tick();
        push({$urandom(), $urandom()});
        push({$urandom(), $urandom()});
        pop_before = pop_cnt;
        enable = 1'b1;
        wait_lo(ok);
        tick();
        tick();
        nreset = 1'b0;
        #1;
        check("midrst_mi_en", 64'(mi_en), 64'd0);
        check("midrst_valid", 64'(msg_valid), 64'd0);
        check("midrst_data", msg_data, 64'd0);
        check("midrst_count", 64'(drain_count), 64'd0);
        check("midrst_popped", 64'(8'(pop_cnt - pop_before)), 64'd1);
        void'(exp_q.pop_front());
        exp_cnt = '0;
        @(negedge clk);
        nreset = 1'b1;
        deliver(0, 1'b0);

        // Counter wrap
        enable = 1'b0;
        tick();
        @(negedge clk);
        force dut.drain_count_q = 16'hFFFF;
        tick();
        release dut.drain_count_q;
        tick();
        check("preload", 64'(drain_count), 64'hFFFF);
        exp_cnt = 16'hFFFF;
        push({$urandom(), $urandom()});
        enable = 1'b1;
        deliver(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/embox_drain.md
# embox_drain

Autonomous drain engine downstream of the mailbox FIFO. It watches `embox_not_empty`, reads each 64-bit message over the mailbox's simple memory interface (low word first, then high word, which pops the entry), and presents the message on a valid/ready stream to the consumer. It replaces host polling when the mailbox feeds on-chip logic such as a DMA descriptor or command queue.

## Interface
Parameters:
- `DW`, 32: mailbox word width; message width is 2*DW.
- `RFAW`, 5: register-file address width; the word index sits in `mi_addr[RFAW+1:2]`.
- `BASE_ADDR`, 20'h0: mailbox base address; index bits are ORed in.
- `LO_IDX`, `EMBOXLO`: word index of the low-word register (non-popping read).
- `HI_IDX`, `EMBOXHI`: word index of the high-word register (popping read).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `nreset`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  drain enable; sampled only in IDLE.
- `embox_not_empty`  in  1  mailbox holds at least one message.
- `mi_en`  out  1  mailbox access strobe, registered.
- `mi_we`  out  1  tied 0; reads only.
- `mi_addr`  out  20  mailbox address, registered.
- `mi_dout`  in  DW  mailbox read data, valid 1 cycle after `mi_en`.
- `msg_valid`  out  1  message available.
- `msg_ready`  in  1  consumer accepts.
- `msg_data`  out  2*DW  message, {high word, low word}.
- `drain_count`  out  16  messages delivered, wraps at 16'hFFFF -> 0.

## Operation
- FSM states: IDLE, RD_LO, RD_HI, CAPT, HOLD.
- IDLE:
  - `enable & embox_not_empty` -> RD_LO.
  - Otherwise stay.
- RD_LO: `mi_en`=1, `mi_addr`=BASE_ADDR | (LO_IDX<<2). Next state RD_HI.
- RD_HI: `mi_en`=1, `mi_addr`=BASE_ADDR | (HI_IDX<<2). This access pops the FIFO. `mi_dout` carries the low word; capture it into `msg_data[DW-1:0]`. Next state CAPT.
- CAPT: `mi_en`=0. `mi_dout` carries the high word; capture it into `msg_data[2*DW-1:DW]`. Next state HOLD.
- HOLD:
  - `msg_valid`=1; `msg_data` is stable.
  - On `msg_valid & msg_ready`: go to IDLE and increment `drain_count`.
- `mi_en` is asserted only in RD_LO and RD_HI, exactly one cycle each. `mi_we` is never 1.
- Dropping `enable` mid-message does not abort; the current message completes through HOLD.
- `embox_not_empty` is ignored outside IDLE. This prevents a re-read of a stale flag during the pop cycle.

## Timing
- Reset values:
  - state IDLE; `mi_en`=0, `mi_we`=0, `mi_addr`=0.
  - `msg_valid`=0, `msg_data`=0, `drain_count`=0.
- Latency: edge where IDLE sees the condition -> RD_LO; `msg_valid` rises 3 cycles later (RD_LO, RD_HI, CAPT, then HOLD).
- Throughput: with `msg_ready` held high, one message per 5 cycles (IDLE, RD_LO, RD_HI, CAPT, HOLD).
- Handshake: `msg_valid` never drops without `msg_ready`, and `msg_data` does not change while valid.
- Reset mid-operation:
  - All state clears immediately.
  - If reset lands after the RD_HI edge, that message is lost; this is accepted behaviour.
  - If reset lands in RD_LO, nothing is popped.
- Full mailbox needs no special handling; the mailbox holds the full state.

## Structure
- The shared mailbox define/package holds the `EMBOXLO` and `EMBOXHI` index constants and the state encoding for this FSM.
- The block is flat with no sub-module; target size is about 150 lines.

## Test plan
- Reset then idle: `nreset` low, then high with `embox_not_empty`=0 -> `mi_en` stays 0, `msg_valid`=0, `drain_count`=0.
- Single message: the mailbox model holds {32'hCAFEF00D, 32'h12345678}, `enable`=1, `msg_ready`=1. Expect:
  - a read of LO then HI on consecutive cycles;
  - `msg_data`=64'hCAFEF00D_12345678 exactly 3 cycles after RD_LO;
  - `drain_count`=1.
- Back-pressure: hold `msg_ready`=0 for 10 cycles with 2 messages queued -> `msg_valid` and `msg_data` stay stable and no `mi_en` occurs. Release -> the second message follows, and `drain_count`=2.
- Enable drop: deassert `enable` the cycle after RD_LO -> the message completes. No further reads occur while 3 messages remain queued.
- Reset mid-operation: assert `nreset`=0 during CAPT -> outputs are at reset values immediately, the mailbox count has decremented by 1, and the next message drains correctly after release.
- Counter wrap: preload 65535 deliveries (or force the counter) -> the next delivery gives `drain_count`=0.
